cpu_player_m: RTL and testbench
===============================

# cpu_player_m

Computer opponent for the tic-tac-toe datapath. On the computer's turn it drives the board's move interface: it snapshots the board, picks a cell, and issues `update_loc` with a clean submit pulse, whose falling edge commits the move. It then waits for the turn to hand back. It sits beside the player input logic, muxed onto the board's `update_loc`/`submit` inputs while `busy` is high.

## Interface
Parameters:
- `CPU_TURN`, default `TURN_PLAYER` inverted (1): the turn value on which this block plays. It places `CELL_O`.
- `WAIT_MAX`, default 8: clocks to wait in WAIT for the turn to flip before flagging `stall`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high block reset.
- `enable`  in  1  computer opponent active.
- `turn`  in  `FLAG_T`  current turn from the board.
- `board`  in  `BOARD_T STATE_T`  cell states, index 0..8 row-major.
- `update_loc`  out  `INDEX_T`  chosen cell. Registered.
- `submit`  out  `FLAG_T`  move strobe. Registered. The board commits on its falling edge.
- `busy`  out  1  high in every state except IDLE.
- `no_move`  out  1  board full on the computer's turn.
- `stall`  out  1  sticky. The turn did not flip within `WAIT_MAX` after a submit.

## Operation
- Reset values: state IDLE, `update_loc` = `INDEX_NONE` (9), `submit` 0, `busy` 0, `no_move` 0, `stall` 0.
- IDLE: when `enable` && `turn == CPU_TURN`:
  - If every cell is non-blank: set `no_move` = 1 and stay in IDLE.
  - Otherwise: clear `no_move`, latch `board` into a snapshot, and go to SCAN.
- SCAN: one cell per clock, index 0..8, always 9 clocks. Records:
  - first blank index;
  - center (4) blank;
  - first blank corner, checked in order 0, 2, 6, 8.
- LINES (SMART only): one line per clock, 8 clocks. Line order: rows 0–2, columns 3–5, diagonal {0,4,8} = 6, diagonal {2,4,6} = 7.
  - A line with two O and one blank records a win at the blank. Only the first win found is kept.
  - A line with two X and one blank records a block at the blank. Only the first block found is kept.
- Selection priority: win > block > center > corner > first blank. Without SMART: first blank only.
- LOAD: register `update_loc` with the selected cell.
- ISSUE: drive `submit` = 1 for 2 clocks.
- RELEASE: drive `submit` = 0. This is the falling edge that commits the move. Then go to WAIT.
- WAIT: return to IDLE when `turn != CPU_TURN`. After `WAIT_MAX` clocks with no flip, set `stall` = 1 and return to IDLE.
- `update_loc` holds its value until the next LOAD.
- `enable` dropping during SCAN or LINES aborts to IDLE with no submit. In LOAD, ISSUE or RELEASE the move completes.
- The selected cell is always blank in the snapshot, so the block never issues an illegal move.

## Timing
- E0 is the rising edge on which IDLE accepts the turn.
- SMART: SCAN covers E1–E9 and LINES covers E10–E17. `update_loc` is valid from E17, `submit` is high from E18, and `submit` falls at E20.
- Without SMART: `update_loc` is valid from E9, `submit` is high from E10, and `submit` falls at E12.
- `update_loc` is stable for at least 1 clock before `submit` rises and until `submit` falls.
- `turn` and `board` are sampled only in IDLE; `board` is read via the snapshot from then on, so changes to either during the move are ignored.
- Reset during ISSUE drops `submit` and changes `update_loc` at the same time, so the board's outcome is undefined. The integrator resets the board together with this block.

## Configuration
- `CPU_SMART_EN` defined: the LINES state and the win/block/center/corner priority are compiled in.
- Undefined: LINES and the priority logic are removed, and the block plays the first blank cell.

## Structure
- `defines.v` gains:
  - `INDEX_NONE` (9);
  - the CPU FSM state encodings;
  - the line table: 8 triples of cell indices.
- Existing `CELL_*`, `TURN_*`, `INDEX_T`, `BOARD_T` and `STATE_T` are reused.
- Sub-module `line_eval_m`: combinational. Takes 3 cell states and returns win, block, and the blank position (0–2).

## Test plan
- SMART, X at {0,1}, O at {4}, CPU turn → `update_loc` = 2 at E17; `submit` high E18–E20, exactly one falling edge.
- SMART, X at {0,1}, O at {3,4} → `update_loc` = 5 (win beats block at 2).
- SMART, X at {0} only → `update_loc` = 4. Then with X at {0,4}, O at {8} → `update_loc` = 2 (first corner).
- Without SMART, X at {0} → `update_loc` = 1 at E9; `submit` high E10–E12.
- Full board on the CPU turn → `no_move` = 1, `busy` = 0, `submit` never rises. `turn` never flips after a submit → `stall` = 1 after 8 clocks.
- Reset asserted mid-LINES, and separately `enable` dropped mid-SCAN → `submit` stays 0, `busy` = 0 on the next clock, `update_loc` = 9 after reset.

Source files
------------

// File: rtl/cpu_player_pkg.sv
// Shared types, cell/turn encodings, CPU FSM states and the line table for the
// tic-tac-toe computer opponent.
package cpu_player_pkg;

    typedef logic        flag_t;
    typedef logic [1:0]  cell_t;
    typedef logic [3:0]  index_t;
    typedef cell_t [8:0] board_t;

    localparam cell_t  CELL_BLANK  = 2'd0;
    localparam cell_t  CELL_X      = 2'd1;
    localparam cell_t  CELL_O      = 2'd2;
    localparam flag_t  TURN_PLAYER = 1'b0;
    localparam index_t INDEX_NONE  = 4'd9;

    typedef enum logic [2:0] {
        CPU_IDLE,
        CPU_SCAN,
        CPU_LINES,
        CPU_LOAD,
        CPU_ISSUE,
        CPU_RELEASE,
        CPU_WAIT
    } cpu_state_e;

    // Each entry holds three cell indices, one per hex digit, first cell in the top digit.
    localparam logic [7:0][11:0] LINE_TBL = {
        12'h246, 12'h048, 12'h258, 12'h147,
        12'h036, 12'h678, 12'h345, 12'h012
    };

    function automatic index_t line_cell(input logic [2:0] line, input logic [1:0] pos);
        logic [11:0] e;
        e = LINE_TBL[line];
        case (pos)
            2'd0:    return e[11:8];
            2'd1:    return e[7:4];
            default: return e[3:0];
        endcase
    endfunction

endpackage

// File: rtl/line_eval_m.sv
// Evaluates one three-cell line: two O plus a blank is a win, two X plus a blank
// is a block. Only built when CPU_SMART_EN is defined.
`ifdef CPU_SMART_EN
module line_eval_m
    import cpu_player_pkg::*;
(
    input  cell_t      a,
    input  cell_t      b,
    input  cell_t      c,
    output logic       win,
    output logic       block,
    output logic [1:0] blank_pos
);

    logic [1:0] n_o, n_x, n_b;

    always_comb begin
        n_o = {1'b0, a == CELL_O} + {1'b0, b == CELL_O} + {1'b0, c == CELL_O};
        n_x = {1'b0, a == CELL_X} + {1'b0, b == CELL_X} + {1'b0, c == CELL_X};
        n_b = {1'b0, a == CELL_BLANK} + {1'b0, b == CELL_BLANK} + {1'b0, c == CELL_BLANK};
        win   = (n_o == 2'd2) && (n_b == 2'd1);
        block = (n_x == 2'd2) && (n_b == 2'd1);
        if (a == CELL_BLANK)      blank_pos = 2'd0;
        else if (b == CELL_BLANK) blank_pos = 2'd1;
        else if (c == CELL_BLANK) blank_pos = 2'd2;
        else                      blank_pos = 2'd0;
    end

endmodule
`endif

// File: rtl/cpu_player_m.sv
// Computer opponent: snapshots the board, picks a blank cell and strobes submit.
// CPU_SMART_EN adds line evaluation and win > block > center > corner priority.
module cpu_player_m
    import cpu_player_pkg::*;
#(
    parameter flag_t CPU_TURN = ~TURN_PLAYER,
    parameter int    WAIT_MAX = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  flag_t  turn,
    input  board_t board,
    output index_t update_loc,
    output flag_t  submit,
    output logic   busy,
    output logic   no_move,
    output logic   stall
);

    localparam int WW = $clog2(WAIT_MAX + 1);

    cpu_state_e    state;
    board_t        snap;
    index_t        scan_idx;
    index_t        first_blank, first_blank_nx;
    index_t        sel;
    logic          issue_cnt;
    logic [WW-1:0] wait_cnt;
    logic          full;
    cell_t         scan_cell;

    assign busy      = (state != CPU_IDLE);
    assign scan_cell = snap[scan_idx];

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (board[i] == CELL_BLANK) full = 1'b0;
    end

    always_comb begin
        first_blank_nx = first_blank;
        if (first_blank == INDEX_NONE && scan_cell == CELL_BLANK)
            first_blank_nx = scan_idx;
    end

`ifdef CPU_SMART_EN
    logic [2:0]  line_idx;
    logic        center_blank, center_nx;
    index_t      corner_loc, corner_nx;
    index_t      win_loc, win_nx, block_loc, block_nx;
    index_t      line_blank;
    logic        l_win, l_block;
    logic [1:0]  l_pos;
    logic        is_corner;

    line_eval_m u_eval (
        .a         (snap[line_cell(line_idx, 2'd0)]),
        .b         (snap[line_cell(line_idx, 2'd1)]),
        .c         (snap[line_cell(line_idx, 2'd2)]),
        .win       (l_win),
        .block     (l_block),
        .blank_pos (l_pos)
    );

    assign line_blank = line_cell(line_idx, l_pos);
    assign is_corner  = (scan_idx == 4'd0) || (scan_idx == 4'd2) ||
                        (scan_idx == 4'd6) || (scan_idx == 4'd8);

    always_comb begin
        center_nx = center_blank || (scan_idx == 4'd4 && scan_cell == CELL_BLANK);
        corner_nx = corner_loc;
        if (corner_loc == INDEX_NONE && is_corner && scan_cell == CELL_BLANK)
            corner_nx = scan_idx;
        win_nx   = (win_loc == INDEX_NONE && l_win) ? line_blank : win_loc;
        block_nx = (block_loc == INDEX_NONE && l_block) ? line_blank : block_loc;
        // The last line's result must count, so select from the next-state values.
        if (win_nx != INDEX_NONE)          sel = win_nx;
        else if (block_nx != INDEX_NONE)   sel = block_nx;
        else if (center_blank)             sel = 4'd4;
        else if (corner_loc != INDEX_NONE) sel = corner_loc;
        else                               sel = first_blank;
    end
`else
    assign sel = first_blank_nx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CPU_IDLE;
            snap        <= '0;
            scan_idx    <= '0;
            first_blank <= INDEX_NONE;
            issue_cnt   <= 1'b0;
            wait_cnt    <= '0;
            update_loc  <= INDEX_NONE;
            submit      <= 1'b0;
            no_move     <= 1'b0;
            stall       <= 1'b0;
`ifdef CPU_SMART_EN
            line_idx     <= '0;
            center_blank <= 1'b0;
            corner_loc   <= INDEX_NONE;
            win_loc      <= INDEX_NONE;
            block_loc    <= INDEX_NONE;
`endif
        end else begin
            case (state)
                CPU_IDLE: if (enable && turn == CPU_TURN) begin
                    if (full) begin
                        no_move <= 1'b1;
                    end else begin
                        no_move     <= 1'b0;
                        snap        <= board;
                        scan_idx    <= '0;
                        first_blank <= INDEX_NONE;
`ifdef CPU_SMART_EN
                        center_blank <= 1'b0;
                        corner_loc   <= INDEX_NONE;
                        win_loc      <= INDEX_NONE;
                        block_loc    <= INDEX_NONE;
`endif
                        state <= CPU_SCAN;
                    end
                end
                CPU_SCAN: if (!enable) begin
                    state <= CPU_IDLE;
                end else begin
                    first_blank <= first_blank_nx;
`ifdef CPU_SMART_EN
                    center_blank <= center_nx;
                    corner_loc   <= corner_nx;
`endif
                    if (scan_idx == 4'd8) begin
                        scan_idx <= '0;
`ifdef CPU_SMART_EN
                        line_idx <= '0;
                        state    <= CPU_LINES;
`else
                        update_loc <= sel;
                        state      <= CPU_LOAD;
`endif
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
`ifdef CPU_SMART_EN
                CPU_LINES: if (!enable) begin
                    state <= CPU_IDLE;
                end else begin
                    win_loc   <= win_nx;
                    block_loc <= block_nx;
                    if (line_idx == 3'd7) begin
                        update_loc <= sel;
                        state      <= CPU_LOAD;
                    end else begin
                        line_idx <= line_idx + 3'd1;
                    end
                end
`endif
                CPU_LOAD: begin
                    submit    <= 1'b1;
                    issue_cnt <= 1'b0;
                    state     <= CPU_ISSUE;
                end
                CPU_ISSUE: if (issue_cnt) begin
                    submit <= 1'b0;
                    state  <= CPU_RELEASE;
                end else begin
                    issue_cnt <= 1'b1;
                end
                CPU_RELEASE: begin
                    wait_cnt <= '0;
                    state    <= CPU_WAIT;
                end
                CPU_WAIT: if (turn != CPU_TURN) begin
                    state <= CPU_IDLE;
                end else if (wait_cnt == WW'(WAIT_MAX - 1)) begin
                    stall <= 1'b1;
                    state <= CPU_IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= CPU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_player_m.sv
// Directed bench for cpu_player_m; follows CPU_SMART_EN to pick vectors and timing.
module tb_cpu_player_m;
    import cpu_player_pkg::*;

`ifdef CPU_SMART_EN
    localparam int LOAD_E = 17;
    localparam int NV     = 7;
`else
    localparam int LOAD_E = 9;
    localparam int NV     = 6;
`endif

    typedef struct {
        logic [8:0] xm;
        logic [8:0] om;
        index_t     exp;
        string      name;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   enable = 1'b0;
    flag_t  turn = 1'b0;
    board_t board = '0;
    index_t update_loc;
    flag_t  submit;
    logic   busy, no_move, stall;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vecs [NV];

    cpu_player_m dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .turn       (turn),
        .board      (board),
        .update_loc (update_loc),
        .submit     (submit),
        .busy       (busy),
        .no_move    (no_move),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic board_t mk(input logic [8:0] xm, input logic [8:0] om);
        board_t b;
        for (int i = 0; i < 9; i++)
            b[i] = xm[i] ? CELL_X : (om[i] ? CELL_O : CELL_BLANK);
        return b;
    endfunction

    // One full move from E0; flip=1 hands the turn back, flip=0 leaves it to stall.
    task automatic run_move(input board_t b, input index_t exp, input string tag, input bit flip);
        int rise, fall, early;
        logic prev;
        rise = 0; fall = 0; early = 0;
        @(negedge clk);
        board = b; turn = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_e0"}, busy, 1);
        prev = submit;
        for (int k = 1; k <= LOAD_E + 3; k++) begin
            @(posedge clk); #1;
            if (submit && !prev) rise++;
            if (!submit && prev) fall++;
            prev = submit;
            if (k <= LOAD_E && submit) early++;
            if (k == LOAD_E)     chk({tag, "_loc"}, update_loc, exp);
            if (k == LOAD_E + 1) chk({tag, "_sub_hi1"}, submit, 1);
            if (k == LOAD_E + 2) chk({tag, "_sub_hi2"}, submit, 1);
        end
        chk({tag, "_sub_early"}, early, 0);
        chk({tag, "_sub_fall"}, submit, 0);
        chk({tag, "_loc_hold"}, update_loc, exp);
        chk({tag, "_rises"}, rise, 1);
        chk({tag, "_falls"}, fall, 1);
        @(negedge clk);
        if (flip) begin
            turn = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk({tag, "_idle_after"}, busy, 0);
            chk({tag, "_no_stall"}, stall, 0);
        end else begin
            enable = 1'b0;
            for (int k = LOAD_E + 4; k <= LOAD_E + 12; k++) begin
                @(posedge clk); #1;
                if (k == LOAD_E + 11) chk({tag, "_stall_early"}, stall, 0);
                if (k == LOAD_E + 12) begin
                    chk({tag, "_stall_set"}, stall, 1);
                    chk({tag, "_stall_idle"}, busy, 0);
                end
            end
            @(negedge clk);
            turn = 1'b0;
        end
    endtask

    initial begin
        int highs;
`ifdef CPU_SMART_EN
        vecs[0] = '{9'b000000011, 9'b000010000, 4'd2, "block2"};
        vecs[1] = '{9'b000000011, 9'b000011000, 4'd5, "win5"};
        vecs[2] = '{9'b000000001, 9'b000000000, 4'd4, "center"};
        vecs[3] = '{9'b000010001, 9'b100000000, 4'd2, "corner2"};
        vecs[4] = '{9'b000010010, 9'b100000001, 4'd7, "block7"};
        vecs[5] = '{9'b010010101, 9'b001101010, 4'd8, "last8"};
        vecs[6] = '{9'b000010000, 9'b000000000, 4'd0, "corner0"};
`else
        vecs[0] = '{9'b000000001, 9'b000000000, 4'd1, "first1"};
        vecs[1] = '{9'b000000000, 9'b000000000, 4'd0, "empty0"};
        vecs[2] = '{9'b000000011, 9'b000010000, 4'd2, "first2"};
        vecs[3] = '{9'b010010101, 9'b001101010, 4'd8, "last8"};
        vecs[4] = '{9'b000000011, 9'b000011000, 4'd2, "nowin2"};
        vecs[5] = '{9'b000001111, 9'b000010000, 4'd5, "first5"};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_loc", update_loc, 9);
        chk("rst_submit", submit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_no_move", no_move, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_move(mk(vecs[i].xm, vecs[i].om), vecs[i].exp, vecs[i].name, 1'b1);

        // Full board on the CPU turn
        @(negedge clk);
        board = mk(9'b101010101, 9'b010101010); turn = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        chk("full_no_move", no_move, 1);
        chk("full_busy", busy, 0);
        highs = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (submit || busy) highs++;
        end
        chk("full_quiet", highs, 0);

        // Enable dropped mid-SCAN
        @(negedge clk);
        board = mk(9'b000000001, 9'b000000000);
        @(posedge clk); #1;
        chk("abort_no_move_clr", no_move, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        highs = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (submit) highs++;
        end
        chk("abort_no_submit", highs, 0);
        @(negedge clk);
        turn = 1'b0;

        run_move(mk(9'b000000001, 9'b000000000), vecs[0].xm == 9'b000000001 ? vecs[0].exp : 4'd4,
                 "stall", 1'b0);

        // Reset asserted mid-way through the evaluation
        @(negedge clk);
        board = mk(9'b000000011, 9'b000010000); turn = 1'b1; enable = 1'b1;
        @(posedge clk);
        repeat (LOAD_E - 5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_loc", update_loc, 9);
        chk("mid_rst_submit", submit, 0);
        chk("mid_rst_stall", stall, 0);
        @(negedge clk);
        enable = 1'b0; turn = 1'b0; reset = 1'b0;
        highs = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (submit || busy) highs++;
        end
        chk("mid_rst_quiet", highs, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
